// File: rtl/io_port_unit_pkg.sv
// Shared constants for the basic computer's I/O responder (package bc_io_pkg).
// Holds the IR(11-6) instruction bit positions, flag reset values and the tx state type.
package bc_io_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DATA_W_DEF = 8;

  // One-hot positions of the register-reference I/O instructions within IR(11-6)
  localparam int IR_INP_BIT = 11;
  localparam int IR_OUT_BIT = 10;
  localparam int IR_SKI_BIT = 9;
  localparam int IR_SKO_BIT = 8;
  localparam int IR_ION_BIT = 7;
  localparam int IR_IOF_BIT = 6;

  localparam logic FGO_RST = 1'b1;
  localparam logic FGI_RST = 1'b0;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_port_unit_if.sv
// Controller strobes plus keyboard/printer byte streams of the I/O responder.
// master = controller/environment side, slave = io_port_unit.
interface io_port_unit_if
  import bc_io_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              io_inp;
  logic              io_out;
  logic              io_ski;
  logic              io_sko;
  logic              io_ion;
  logic              io_iof;
  logic              int_ack;
  logic              instr_cyc;
  logic [WIDTH-1:0]  ac_in;
  logic [DATA_W-1:0] inpr;
  logic              skip;
  logic              fgi;
  logic              fgo;
  logic              ien;
  logic              irq;
  logic              ovr_err;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;

  modport master (
    output io_inp, io_out, io_ski, io_sko, io_ion, io_iof, int_ack, instr_cyc, ac_in,
    output rx_valid, rx_data, tx_ready,
    input  inpr, skip, fgi, fgo, ien, irq, ovr_err, rx_ready, tx_valid, tx_data
  );

  modport slave (
    input  io_inp, io_out, io_ski, io_sko, io_ion, io_iof, int_ack, instr_cyc, ac_in,
    input  rx_valid, rx_data, tx_ready,
    output inpr, skip, fgi, fgo, ien, irq, ovr_err, rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/io_port_unit_rx_fifo.sv
// Keyboard receive FIFO (module io_rx_fifo); head shows the oldest byte, 0 when empty.
// Used by io_port_unit only when IO_RX_FIFO_EN is defined.
module io_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_s;
  logic              pop_s;

  assign full   = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign head   = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/io_port_unit.sv
// I/O responder for INP/OUT/SKI/SKO/ION/IOF: INPR/OUTR, FGI/FGO, IEN and interrupt flip-flop R.
// Define IO_RX_FIFO_EN to replace the single INPR register with an io_rx_fifo receive queue.
module io_port_unit
  import bc_io_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  io_port_unit_if.slave bus
);
  tx_state_e         tx_state_r;
  tx_state_e         tx_state_s;
  logic [DATA_W-1:0] outr_r;
  logic              ovr_err_r;
  logic              ien_r;
  logic              irq_r;
  logic              fgi_s;
  logic              fgo_s;
  logic              rx_ready_s;
  logic              rx_push_s;
  logic              rx_pop_s;
  logic [DATA_W-1:0] inpr_s;
  logic              unused_ac_s;

  assign unused_ac_s = ^bus.ac_in[WIDTH-1:DATA_W];
  assign rx_push_s   = bus.rx_valid & rx_ready_s;
  assign rx_pop_s    = bus.io_inp & fgi_s;

`ifdef IO_RX_FIFO_EN
  logic fifo_full_s;
  logic fifo_empty_s;

  io_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push_s),
    .pop  (rx_pop_s),
    .wdata(bus.rx_data),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .head (inpr_s)
  );

  assign rx_ready_s = ~fifo_full_s;
  assign fgi_s      = ~fifo_empty_s;
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic [DATA_W-1:0] inpr_r;
  logic              fgi_r;

  // Single-byte receive buffer: a keyboard byte loads only while FGI is clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr_r <= {DATA_W{1'b0}};
      fgi_r  <= FGI_RST;
    end else if (rx_push_s) begin
      inpr_r <= bus.rx_data;
      fgi_r  <= 1'b1;
    end else if (rx_pop_s) begin
      fgi_r  <= 1'b0;
    end
  end

  assign rx_ready_s = ~fgi_r;
  assign fgi_s      = fgi_r;
  assign inpr_s     = inpr_r;
`endif

  // FGO is the complement of "byte waiting for the printer", so both come from the tx state
  assign fgo_s = (tx_state_r == TX_IDLE);

  // Tx state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
    end else begin
      tx_state_r <= tx_state_s;
    end
  end

  // Tx next state: OUT starts a transfer, printer handshake completes it
  always_comb begin
    tx_state_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (bus.io_out) begin
          tx_state_s = TX_BUSY;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_BUSY: begin
        if (bus.tx_ready) begin
          tx_state_s = TX_IDLE;
        end else begin
          tx_state_s = TX_BUSY;
        end
      end
      default: tx_state_s = TX_IDLE;
    endcase
  end

  // OUTR loads only when the printer side is free; an OUT while busy latches the overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outr_r    <= {DATA_W{1'b0}};
      ovr_err_r <= 1'b0;
    end else if (bus.io_out) begin
      if (fgo_s) begin
        outr_r    <= bus.ac_in[DATA_W-1:0];
      end else begin
        ovr_err_r <= 1'b1;
      end
    end
  end

  // IEN priority int_ack > IOF > ION; R is cleared by int_ack ahead of any set condition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien_r <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      if (bus.int_ack || bus.io_iof) begin
        ien_r <= 1'b0;
      end else if (bus.io_ion) begin
        ien_r <= 1'b1;
      end
      if (bus.int_ack) begin
        irq_r <= 1'b0;
      end else if (ien_r && (fgi_s || fgo_s) && bus.instr_cyc) begin
        irq_r <= 1'b1;
      end
    end
  end

  assign bus.skip     = (bus.io_ski & fgi_s) | (bus.io_sko & fgo_s);
  assign bus.inpr     = inpr_s;
  assign bus.fgi      = fgi_s;
  assign bus.fgo      = fgo_s;
  assign bus.ien      = ien_r;
  assign bus.irq      = irq_r;
  assign bus.ovr_err  = ovr_err_r;
  assign bus.rx_ready = rx_ready_s;
  assign bus.tx_valid = (tx_state_r == TX_BUSY);
  assign bus.tx_data  = outr_r;
endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit; tx bytes and INP reads are checked by a scoreboard monitor.
// Define IO_RX_FIFO_EN for both bench and RTL to exercise the receive FIFO build.
module tb_io_port_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails = 0;
  logic [7:0] tx_q[$];
  logic [7:0] inp_q[$];

  io_port_unit_if #(.WIDTH(16), .DATA_W(8)) bus ();

  io_port_unit #(.WIDTH(16), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: printer handshakes and INP reads consume expected bytes
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
    end
    if (!rst && bus.io_inp && bus.fgi) begin
      if (inp_q.size() == 0) begin
        check("inp_unexpected", 32'(bus.inpr), 32'hFFFF_FFFF);
      end else begin
        check("inp_byte", 32'(bus.inpr), 32'(inp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.io_inp = 1'b0; bus.io_out = 1'b0; bus.io_ski = 1'b0; bus.io_sko = 1'b0;
    bus.io_ion = 1'b0; bus.io_iof = 1'b0; bus.int_ack = 1'b0; bus.instr_cyc = 1'b0;
    bus.ac_in = 16'h0000; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_fgo", 32'(bus.fgo), 32'd1);
    check("rst_fgi", 32'(bus.fgi), 32'd0);
    check("rst_ien", 32'(bus.ien), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_ovr_err", 32'(bus.ovr_err), 32'd0);
    check("rst_inpr", 32'(bus.inpr), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);

    // Receive one keyboard byte
    bus.rx_data = 8'h41; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    check("rx_fgi", 32'(bus.fgi), 32'd1);
    check("rx_inpr", 32'(bus.inpr), 32'h41);
`ifndef IO_RX_FIFO_EN
    check("rx_ready_full", 32'(bus.rx_ready), 32'd0);
    bus.rx_data = 8'h42; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    check("rx_blocked_inpr", 32'(bus.inpr), 32'h41);
    check("rx_blocked_fgi", 32'(bus.fgi), 32'd1);
`else
    check("rx_ready_fifo", 32'(bus.rx_ready), 32'd1);
`endif
    bus.io_ski = 1'b1; #1 check("ski_skip", 32'(bus.skip), 32'd1);
    bus.io_ski = 1'b0; bus.io_sko = 1'b1; #1 check("sko_skip", 32'(bus.skip), 32'd1);
    bus.io_sko = 1'b0; #1 check("no_skip", 32'(bus.skip), 32'd0);
    bus.io_inp = 1'b1; inp_q.push_back(8'h41); tick(); bus.io_inp = 1'b0;
    check("inp_fgi_clr", 32'(bus.fgi), 32'd0);
    check("inp_rx_ready", 32'(bus.rx_ready), 32'd1);
`ifndef IO_RX_FIFO_EN
    check("inp_inpr_kept", 32'(bus.inpr), 32'h41);
`else
    check("inp_inpr_empty", 32'(bus.inpr), 32'h00);
`endif
    bus.io_inp = 1'b1; tick(); bus.io_inp = 1'b0;
    check("inp_idle_fgi", 32'(bus.fgi), 32'd0);
    bus.io_ski = 1'b1; #1 check("ski_noskip", 32'(bus.skip), 32'd0);
    bus.io_ski = 1'b0;

    // Transmit with a stalled printer, then an overrun attempt
    bus.ac_in = 16'h1234; bus.io_out = 1'b1; tx_q.push_back(8'h34); tick(); bus.io_out = 1'b0;
    check("tx_data", 32'(bus.tx_data), 32'h34);
    check("tx_valid", 32'(bus.tx_valid), 32'd1);
    check("tx_fgo", 32'(bus.fgo), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
      check("tx_hold_data", 32'(bus.tx_data), 32'h34);
    end
    check("tx_no_ovr", 32'(bus.ovr_err), 32'd0);
    bus.io_sko = 1'b1; #1 check("sko_noskip", 32'(bus.skip), 32'd0);
    bus.io_sko = 1'b0;
    bus.ac_in = 16'h5678; bus.io_out = 1'b1; tick(); bus.io_out = 1'b0;
    check("ovr_err_set", 32'(bus.ovr_err), 32'd1);
    check("ovr_outr_kept", 32'(bus.tx_data), 32'h34);
    check("ovr_valid_kept", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0;
    check("tx_done_valid", 32'(bus.tx_valid), 32'd0);
    check("tx_done_fgo", 32'(bus.fgo), 32'd1);
    check("ovr_sticky", 32'(bus.ovr_err), 32'd1);

    // Interrupt enable and R flip-flop
    bus.io_ion = 1'b1; tick(); bus.io_ion = 1'b0;
    check("ion_ien", 32'(bus.ien), 32'd1);
    check("irq_needs_cyc", 32'(bus.irq), 32'd0);
    bus.instr_cyc = 1'b1; tick(); bus.instr_cyc = 1'b0;
    check("irq_set", 32'(bus.irq), 32'd1);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    check("ack_irq", 32'(bus.irq), 32'd0);
    check("ack_ien", 32'(bus.ien), 32'd0);
    bus.io_ion = 1'b1; tick(); bus.io_ion = 1'b0;
    bus.instr_cyc = 1'b1; bus.int_ack = 1'b1; tick(); bus.instr_cyc = 1'b0; bus.int_ack = 1'b0;
    check("ack_wins_irq", 32'(bus.irq), 32'd0);
    check("ack_wins_ien", 32'(bus.ien), 32'd0);
    bus.io_ion = 1'b1; tick(); bus.io_ion = 1'b0;
    check("ion_again", 32'(bus.ien), 32'd1);
    bus.io_ion = 1'b1; bus.io_iof = 1'b1; tick(); bus.io_ion = 1'b0; bus.io_iof = 1'b0;
    check("iof_wins", 32'(bus.ien), 32'd0);

`ifdef IO_RX_FIFO_EN
    // Fill, reject when full, push+pop at three entries, drain across the wrap
    for (int i = 1; i <= 4; i++) begin
      bus.rx_data = 8'(i); bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    end
    check("fifo_full_ready", 32'(bus.rx_ready), 32'd0);
    check("fifo_fgi", 32'(bus.fgi), 32'd1);
    check("fifo_head", 32'(bus.inpr), 32'h01);
    bus.rx_data = 8'h09; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    check("fifo_reject", 32'(bus.inpr), 32'h01);
    bus.io_inp = 1'b1; inp_q.push_back(8'h01); tick(); bus.io_inp = 1'b0;
    check("fifo_three_ready", 32'(bus.rx_ready), 32'd1);
    check("fifo_head2", 32'(bus.inpr), 32'h02);
    bus.rx_data = 8'h05; bus.rx_valid = 1'b1; bus.io_inp = 1'b1; inp_q.push_back(8'h02);
    tick(); bus.rx_valid = 1'b0; bus.io_inp = 1'b0;
    check("fifo_pp_ready", 32'(bus.rx_ready), 32'd1);
    check("fifo_pp_head", 32'(bus.inpr), 32'h03);
    bus.rx_data = 8'h06; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    check("fifo_count3_full", 32'(bus.rx_ready), 32'd0);
    inp_q.push_back(8'h03); inp_q.push_back(8'h04); inp_q.push_back(8'h05); inp_q.push_back(8'h06);
    bus.io_inp = 1'b1; repeat (4) tick(); bus.io_inp = 1'b0;
    check("fifo_drain_fgi", 32'(bus.fgi), 32'd0);
    check("fifo_drain_inpr", 32'(bus.inpr), 32'h00);
    check("fifo_drain_ready", 32'(bus.rx_ready), 32'd1);
`endif

    // Asynchronous reset while a byte waits for the printer
    bus.ac_in = 16'h00AB; bus.io_out = 1'b1; tick(); bus.io_out = 1'b0;
    check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("arst_fgo", 32'(bus.fgo), 32'd1);
    check("arst_tx_data", 32'(bus.tx_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_ovr_clr", 32'(bus.ovr_err), 32'd0);
    check("arst_fgo_held", 32'(bus.fgo), 32'd1);

    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("inp_q_drained", 32'(inp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
